// File: rtl/my_node_info_pkg.sv
// ============================================================================
// Module : my_node_info_pkg
// Brief  : Shared network constants: packet-type codes and energy costs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package my_node_info_pkg;

    localparam int PKT_TYPE_W = 3;

    localparam logic [PKT_TYPE_W-1:0] PKT_HB   = 3'b000;
    localparam logic [PKT_TYPE_W-1:0] PKT_CHE  = 3'b001;
    localparam logic [PKT_TYPE_W-1:0] PKT_INV  = 3'b010;
    localparam logic [PKT_TYPE_W-1:0] PKT_CHTS = 3'b100;
    localparam logic [PKT_TYPE_W-1:0] PKT_DATA = 3'b101;

    // Energy costs in Q2.14, consumed by the radio/energy model blocks
    localparam logic [15:0] RX_PKT_NRG = 16'h0004;
    localparam logic [15:0] HOP1_TX    = 16'h0005;
    localparam logic [15:0] HOP4_TX    = 16'h001B;

endpackage

`default_nettype wire

// File: rtl/my_node_info_qcalc.sv
// ============================================================================
// Module : mni_qcalc
// Brief  : Combinational Q-value: energy / hops, truncated; hops=0 passes energy.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mni_qcalc #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] energy,
    input  logic [WIDTH-1:0] hops,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = energy;
        if (hops != '0) begin
            q = energy / hops;
        end
    end

endmodule

`default_nettype wire

// File: rtl/my_node_info.sv
// ============================================================================
// Module : my_node_info
// Brief  : Per-node routing/role state updated by strobed packet fields.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module my_node_info
    import my_node_info_pkg::*;
#(
    parameter int              WIDTH   = 16,
    parameter logic [WIDTH-1:0] NODE_ID = 16'h000C
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en_MNI,
    input  logic [PKT_TYPE_W-1:0] fPktType,
    input  logic [WIDTH-1:0]      energy,
    input  logic [WIDTH-1:0]      destinationID,
    input  logic [WIDTH-1:0]      hops,
    input  logic [WIDTH-1:0]      timeslot,
    input  logic [WIDTH-1:0]      e_threshold,
    output logic [WIDTH-1:0]      myNodeID,
    output logic [WIDTH-1:0]      hopsFromSink,
    output logic [WIDTH-1:0]      myQValue,
    output logic                  role,
    output logic                  low_E
);

    logic             r_hb_lock;
    logic [WIDTH-1:0] w_q;
    logic             w_dest_match;
    logic             w_low_energy;
    logic             w_unused_timeslot;

    // The slot number is carried by CHTS but intentionally not retained here
    assign w_unused_timeslot = ^timeslot;

    assign myNodeID     = NODE_ID;
    assign w_dest_match = (destinationID == NODE_ID);
    assign w_low_energy = (energy < e_threshold);

    mni_qcalc #(
        .WIDTH (WIDTH)
    ) u_qcalc (
        .energy (energy),
        .hops   (hops),
        .q      (w_q)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hopsFromSink <= '1;
            myQValue     <= '0;
            role         <= 1'b0;
            low_E        <= 1'b0;
            r_hb_lock    <= 1'b0;
        end else if (en_MNI) begin
            low_E <= w_low_energy;
            case (fPktType)
                PKT_HB: begin
                    if (!r_hb_lock) begin
                        hopsFromSink <= hops;
                        myQValue     <= w_q;
                        role         <= 1'b0;
                        r_hb_lock    <= 1'b1;
                    end
                end
                PKT_CHE: begin
                    role <= w_dest_match;
                end
                PKT_CHTS: begin
                    if (w_dest_match && !role) begin
                        r_hb_lock    <= 1'b0;
                        hopsFromSink <= hops;
                    end
                end
                PKT_DATA: begin
                    r_hb_lock <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_my_node_info.sv
// ============================================================================
// Module : tb_my_node_info
// Brief  : Directed vectors with queued expectations checked by a monitor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_my_node_info;

    typedef struct packed {
        logic [15:0] hops;
        logic [15:0] q;
        logic        role;
        logic        low_e;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        en_MNI = 1'b0;
    logic [2:0]  fPktType = 3'b010;
    logic [15:0] energy = 16'h8000;
    logic [15:0] destinationID = 16'h0000;
    logic [15:0] hops = 16'h0000;
    logic [15:0] timeslot = 16'h0000;
    logic [15:0] e_threshold = 16'h3333;
    logic [15:0] myNodeID;
    logic [15:0] hopsFromSink;
    logic [15:0] myQValue;
    logic        role;
    logic        low_E;

    exp_t  sb_q[$];
    string nm_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    my_node_info dut (
        .clk           (clk),
        .nrst          (nrst),
        .en_MNI        (en_MNI),
        .fPktType      (fPktType),
        .energy        (energy),
        .destinationID (destinationID),
        .hops          (hops),
        .timeslot      (timeslot),
        .e_threshold   (e_threshold),
        .myNodeID      (myNodeID),
        .hopsFromSink  (hopsFromSink),
        .myQValue      (myQValue),
        .role          (role),
        .low_E         (low_E)
    );

    // Monitor: compares every queued expectation on the falling edge
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t  x;
            string nm;
            x  = sb_q.pop_front();
            nm = nm_q.pop_front();
            n_cmp++;
            if (hopsFromSink !== x.hops || myQValue !== x.q || role !== x.role ||
                low_E !== x.low_e || myNodeID !== 16'h000C) begin
                n_bad++;
                $display("FAIL %s: got hops=%h q=%h role=%b lowE=%b id=%h, want hops=%h q=%h role=%b lowE=%b id=000c",
                         nm, hopsFromSink, myQValue, role, low_E, myNodeID,
                         x.hops, x.q, x.role, x.low_e);
            end
        end
    end

    function automatic exp_t mk(input logic [15:0] h, input logic [15:0] q,
                                input logic r, input logic le);
        exp_t x;
        x.hops = h; x.q = q; x.role = r; x.low_e = le;
        return x;
    endfunction

    task automatic send(input logic [2:0] t, input logic [15:0] e,
                        input logic [15:0] d, input logic [15:0] h,
                        input logic strobe, input exp_t x, input string nm);
        @(negedge clk);
        en_MNI = strobe; fPktType = t; energy = e; destinationID = d; hops = h;
        timeslot = timeslot + 16'd1;
        @(posedge clk);
        #1;
        en_MNI = 1'b0;
        sb_q.push_back(x);
        nm_q.push_back(nm);
    endtask

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        sb_q.push_back(mk(16'hFFFF, 16'h0000, 1'b0, 1'b0)); nm_q.push_back("reset_state");
        @(negedge clk);
        #2 nrst = 1'b1;

        send(3'b000, 16'h7FFC, 16'h0000, 16'd1, 1'b1, mk(16'd1, 16'h7FFC, 1'b0, 1'b0), "hb_first");
        send(3'b000, 16'h7FF8, 16'h0000, 16'd2, 1'b1, mk(16'd1, 16'h7FFC, 1'b0, 1'b0), "hb_locked_drop");
        send(3'b001, 16'h7FF8, 16'd32,   16'd0, 1'b1, mk(16'd1, 16'h7FFC, 1'b0, 1'b0), "che_other");
        send(3'b001, 16'h7FF8, 16'h000C, 16'd0, 1'b1, mk(16'd1, 16'h7FFC, 1'b1, 1'b0), "che_self");
        send(3'b100, 16'h7FF8, 16'h000C, 16'd5, 1'b1, mk(16'd1, 16'h7FFC, 1'b1, 1'b0), "chts_as_ch");
        send(3'b101, 16'h7FF8, 16'd14,   16'd9, 1'b1, mk(16'd1, 16'h7FFC, 1'b1, 1'b0), "data_unlock");
        send(3'b000, 16'h6000, 16'h0000, 16'd3, 1'b1, mk(16'd3, 16'h2000, 1'b0, 1'b0), "hb_after_data");
        send(3'b010, 16'h3000, 16'h000C, 16'd8, 1'b1, mk(16'd3, 16'h2000, 1'b0, 1'b1), "inv_low_e");
        send(3'b010, 16'h3333, 16'h000C, 16'd8, 1'b1, mk(16'd3, 16'h2000, 1'b0, 1'b0), "inv_equal_thr");
        send(3'b111, 16'h0000, 16'h000C, 16'd8, 1'b1, mk(16'd3, 16'h2000, 1'b0, 1'b1), "undef_type");
        send(3'b100, 16'h4000, 16'h000C, 16'd7, 1'b1, mk(16'd7, 16'h2000, 1'b0, 1'b0), "chts_member");
        send(3'b000, 16'h1234, 16'h0000, 16'd0, 1'b1, mk(16'd0, 16'h1234, 1'b0, 1'b1), "hb_hops_zero");
        send(3'b101, 16'h7000, 16'h0000, 16'd5, 1'b0, mk(16'd0, 16'h1234, 1'b0, 1'b1), "idle_hold");
        send(3'b100, 16'h4000, 16'h000D, 16'd6, 1'b1, mk(16'd0, 16'h1234, 1'b0, 1'b0), "chts_mismatch");
        send(3'b000, 16'h4000, 16'h0000, 16'd4, 1'b1, mk(16'd0, 16'h1234, 1'b0, 1'b0), "hb_still_locked");

        // Reset asserted while a strobe is being presented
        @(negedge clk);
        en_MNI = 1'b1; fPktType = 3'b000; energy = 16'h1000; hops = 16'd1;
        #1 nrst = 1'b0;
        #1;
        sb_q.push_back(mk(16'hFFFF, 16'h0000, 1'b0, 1'b0)); nm_q.push_back("async_reset");
        @(posedge clk);
        #1;
        sb_q.push_back(mk(16'hFFFF, 16'h0000, 1'b0, 1'b0)); nm_q.push_back("reset_ignores_strobe");
        @(negedge clk);
        #2;
        en_MNI = 1'b0;
        nrst = 1'b1;

        send(3'b000, 16'h8000, 16'h0000, 16'd2, 1'b1, mk(16'd2, 16'h4000, 1'b0, 1'b0), "hb_after_reset");

        begin
            int guard = 0;
            while (sb_q.size() > 0 && guard < 20) begin
                @(posedge clk);
                guard++;
            end
            if (sb_q.size() > 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
            end
        end
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/my_node_info.md
MY_NODE_INFO -- requirements
Module: my_node_info

Interface
REQ-001 Parameter NODE_ID, default 16'h000C, this node's fixed identifier.
REQ-002 Parameter WIDTH, default 16, width of all word-sized ports.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 en_MNI  input  1  one-cycle strobe: process the packet fields currently presented.
REQ-006 fPktType  input  3  packet type: 000 HB, 001 CHE, 010 INV, 100 CHTS (CH timeslot), 101 DATA; others ignored.
REQ-007 energy  input  16  residual energy, unsigned Q2.14 (16'h8000 = 2.0).
REQ-008 destinationID  input  16  destination node ID carried by CHE/CHTS/DATA.
REQ-009 hops  input  16  hop count carried by HB/CHTS/DATA.
REQ-010 timeslot  input  16  slot number carried by CHTS.
REQ-011 e_threshold  input  16  low-energy threshold, Q2.14.
REQ-012 myNodeID  output  16  constant NODE_ID.
REQ-013 hopsFromSink  output  16  hop distance to sink learned from HB.
REQ-014 myQValue  output  16  node Q-value, Q2.14.
REQ-015 role  output  1  1 = cluster head this round, 0 = member.
REQ-016 low_E  output  1  1 = energy below threshold.

Function
REQ-017 Inputs other than en_MNI SHALL be sampled only on a rising edge where en_MNI=1; results SHALL be visible on registered outputs immediately after that edge (latency 1 cycle); en_MNI=0 SHALL hold all state.
REQ-018 Internal flag HBLock SHALL gate HB acceptance.
REQ-019 HB with HBLock=0: hopsFromSink<=hops, myQValue<=Q(energy,hops), role<=0, HBLock<=1.
REQ-020 HB with HBLock=1: packet dropped; hopsFromSink, myQValue, role unchanged.
REQ-021 Q(energy,hops) = energy / hops, unsigned integer division truncated, 16-bit result; hops=0 yields energy unchanged.
REQ-022 CHE: role<=1 if destinationID==NODE_ID, else role<=0; HBLock unchanged.
REQ-023 INV and undefined types: no state change except low_E.
REQ-024 DATA: HBLock<=0; no other change except low_E.
REQ-025 CHTS with destinationID==NODE_ID and role=0: HBLock<=0, hopsFromSink<=hops; with mismatch or role=1: no change except low_E; timeslot value is not stored.
REQ-026 Every accepted en_MNI (any type) SHALL update low_E<=(energy < e_threshold), unsigned compare; equality gives 0.
REQ-027 myNodeID SHALL equal NODE_ID at all times, including during reset.

Reset
REQ-028 nrst=0 SHALL asynchronously force hopsFromSink=16'hFFFF, myQValue=16'h0000, role=0, low_E=0, HBLock=0, regardless of en_MNI; reset mid-operation discards any pending strobe.
REQ-029 After nrst deasserts, first HB SHALL be accepted.

Structure
REQ-030 Packet-type codes (HB, CHE, INV, CHTS, DATA) and energy-cost constants (RX_PKT_NRG=16'h0004, HOP1_TX=16'h0005, HOP4_TX=16'h001B) SHALL live in a shared network package.
REQ-031 Q-value division SHALL be a combinational sub-module mni_qcalc (energy, hops -> q); remainder of block is a single register process plus decode logic.

Verification
REQ-032 Reset, energy=16'h8000 -> hopsFromSink=16'hFFFF, myQValue=0, role=0, low_E=0, myNodeID=16'h000C.
REQ-033 HB hops=1, energy=16'h7FFC, e_threshold=16'h3333, one en_MNI pulse -> hopsFromSink=1, myQValue=16'h7FFC, low_E=0; then HB hops=2, energy=16'h7FF8 -> hopsFromSink=1, myQValue=16'h7FFC (dropped).
REQ-034 CHE destinationID=32 -> role=0; then CHE destinationID=16'h000C -> role=1.
REQ-035 DATA destinationID=14 then HB hops=3, energy=16'h6000 -> HBLock cleared, hopsFromSink=3, myQValue=16'h2000, role=0.
REQ-036 Any packet with energy=16'h3000, e_threshold=16'h3333 -> low_E=1; energy=16'h3333 -> low_E=0.
REQ-037 Assert nrst low while en_MNI=1 with HB hops=1 -> outputs stay at reset values; next HB after release is accepted.
